// File: rtl/wfg_cfg_loader_pkg.sv
// wfg_cfg_loader_pkg: shared types and constants for the config-script loader.
// Optional macro used by the loader: WFG_CFG_LOADER_READBACK_EN.
package wfg_cfg_loader_pkg;

    // Loader sequencing states; the RB_* states are only reachable with read-back enabled.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_A   = 4'd1,
        ST_LAT_A  = 4'd2,
        ST_RD_D   = 4'd3,
        ST_LAT_D  = 4'd4,
        ST_WB_WR  = 4'd5,
        ST_RB_GAP = 4'd6,
        ST_RB_RD  = 4'd7,
        ST_RB_CMP = 4'd8,
        ST_NEXT   = 4'd9,
        ST_FIN    = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_OVERRUN  = 2'd2,
        ERR_MISMATCH = 2'd3
    } err_code_e;

    // Script entry word0 = {last, reserved, register address}
    localparam int LAST_BIT = 31;
    localparam int ADR_MSB  = 7;

endpackage

// File: rtl/wfg_cfg_loader.sv
// wfg_cfg_loader: replays (address, data) pairs from the config SRAM as Wishbone writes
// so the waveform generator can configure itself after reset.
// Optional macro WFG_CFG_LOADER_READBACK_EN: read each register back after writing it and
// stop with a mismatch error if the value differs.
// Bus handshake: cyc/stb rise together, stay stable until ack_i is sampled high and fall
// in the following cycle; at least one idle cycle separates two bus cycles.
module wfg_cfg_loader
    import wfg_cfg_loader_pkg::*;
#(
    parameter int BUSW           = 32,
    parameter int MEM_AW         = 10,
    parameter int MAX_ENTRIES    = 256,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [MEM_AW-1:0] start_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       entry_cnt_o,
    output logic              csb_o,
    output logic [MEM_AW-1:0] addr_o,
    input  logic [31:0]       dout_i,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [BUSW-1:0]   wbm_adr_o,
    output logic [BUSW-1:0]   wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    input  logic              wbm_ack_i,
    input  logic [BUSW-1:0]   wbm_dat_i,
    output logic [3:0]        dbg_state_o
);

    localparam int              TOW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TOW-1:0]  TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     MAX_CNT = 16'(MAX_ENTRIES);

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              csb_q, csb_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADR_MSB:0]  adr_q, adr_d;
    logic [BUSW-1:0]   dat_q, dat_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;
    logic [15:0]       entry_cnt_q, entry_cnt_d;
    logic [TOW-1:0]    to_cnt_q, to_cnt_d;
`ifdef WFG_CFG_LOADER_READBACK_EN
    logic [BUSW-1:0]   rdat_q, rdat_d;
`else
    logic              unused_rdat;
    assign unused_rdat = ^wbm_dat_i;
`endif

    // Next-state and next-output logic for the script sequencer
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        csb_d       = 1'b1;
        addr_d      = addr_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
        entry_cnt_d = entry_cnt_q;
        to_cnt_d    = to_cnt_q;
`ifdef WFG_CFG_LOADER_READBACK_EN
        rdat_d      = rdat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_RD_A;
                    ptr_d       = start_addr_i;
                    csb_d       = 1'b0;
                    addr_d      = start_addr_i;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    err_code_d  = ERR_NONE;
                    entry_cnt_d = '0;
                end
            end
            ST_RD_A: state_d = ST_LAT_A;
            ST_LAT_A: begin
                adr_d   = dout_i[ADR_MSB:0];
                last_d  = dout_i[LAST_BIT];
                csb_d   = 1'b0;
                addr_d  = ptr_q + MEM_AW'(1);
                state_d = ST_RD_D;
            end
            ST_RD_D: state_d = ST_LAT_D;
            ST_LAT_D: begin
                dat_d    = BUSW'(dout_i);
                cyc_d    = 1'b1;
                we_d     = 1'b1;
                to_cnt_d = '0;
                state_d  = ST_WB_WR;
            end
            ST_WB_WR: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
`ifdef WFG_CFG_LOADER_READBACK_EN
                    state_d = ST_RB_GAP;
`else
                    state_d = ST_NEXT;
`endif
                end else if (to_cnt_q == TO_LAST) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    if (!err_q) err_code_d = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                end
            end
`ifdef WFG_CFG_LOADER_READBACK_EN
            ST_RB_GAP: begin
                cyc_d    = 1'b1;
                we_d     = 1'b0;
                to_cnt_d = '0;
                state_d  = ST_RB_RD;
            end
            ST_RB_RD: begin
                if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    rdat_d  = wbm_dat_i;
                    state_d = ST_RB_CMP;
                end else if (to_cnt_q == TO_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!err_q) err_code_d = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                end
            end
            ST_RB_CMP: begin
                if (rdat_q != dat_q) begin
                    err_d   = 1'b1;
                    if (!err_q) err_code_d = ERR_MISMATCH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_NEXT;
                end
            end
`endif
            ST_NEXT: begin
                entry_cnt_d = entry_cnt_q + 16'd1;
                ptr_d       = ptr_q + MEM_AW'(2);
                if (last_q || abort_i) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else if (entry_cnt_q + 16'd1 == MAX_CNT) begin
                    err_d   = 1'b1;
                    if (!err_q) err_code_d = ERR_OVERRUN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    csb_d   = 1'b0;
                    addr_d  = ptr_q + MEM_AW'(2);
                    state_d = ST_RD_A;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus immediately
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            csb_q       <= 1'b1;
            addr_q      <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            entry_cnt_q <= '0;
            to_cnt_q    <= '0;
`ifdef WFG_CFG_LOADER_READBACK_EN
            rdat_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            csb_q       <= csb_d;
            addr_q      <= addr_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            entry_cnt_q <= entry_cnt_d;
            to_cnt_q    <= to_cnt_d;
`ifdef WFG_CFG_LOADER_READBACK_EN
            rdat_q      <= rdat_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign entry_cnt_o = entry_cnt_q;
    assign csb_o       = csb_q;
    assign addr_o      = addr_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = cyc_q ? BUSW'(adr_q) : '0;
    assign wbm_dat_o   = (cyc_q && we_q) ? dat_q : '0;
    assign wbm_sel_o   = cyc_q ? 4'hF : 4'h0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wfg_cfg_loader.sv
// tb_wfg_cfg_loader: table-driven scripts plus hand sequences for abort, read-back
// mismatch and reset during a bus cycle. Optional macro: WFG_CFG_LOADER_READBACK_EN.
module tb_wfg_cfg_loader;

`ifdef WFG_CFG_LOADER_READBACK_EN
    localparam int ENTRY_CYC = 9;
`else
    localparam int ENTRY_CYC = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [9:0]  start_addr_i = '0;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [15:0] entry_cnt_o;
    logic        csb_o;
    logic [9:0]  addr_o;
    logic [31:0] dout_i = '0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic [3:0]  dbg_state_o;

    wfg_cfg_loader #(.BUSW(32), .MEM_AW(10), .MAX_ENTRIES(4), .TIMEOUT_CYCLES(255)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
        .start_addr_i(start_addr_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .entry_cnt_o(entry_cnt_o), .csb_o(csb_o), .addr_o(addr_o),
        .dout_i(dout_i), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SRAM model: one-cycle read latency
    logic [31:0] sram [0:1023];
    always @(posedge clk) if (!csb_o) dout_i <= sram[addr_o];

    logic [7:0]  adr_t [6] = '{8'h10, 8'h20, 8'h50, 8'h30, 8'h40, 8'h60};
    logic [31:0] dat_t [6] = '{32'h1, 32'h5, 32'hA, 32'h7, 32'h9, 32'hB};

    task automatic clear_sram();
        for (int i = 0; i < 1024; i++) sram[i] = '0;
    endtask

    task automatic load_script(input logic [9:0] base, input int n, input bit use_last);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 10'(2 * i);
            sram[a] = {(use_last && i == n - 1), 23'b0, adr_t[i]};
            a = a + 10'd1;
            sram[a] = dat_t[i];
        end
    endtask

    // Scoreboard and slave model
    logic [39:0] exp_q[$];
    logic [31:0] slave_mem [0:255];
    int          ack_dly = 0;
    logic [7:0]  stall_adr = 8'h00;
    bit          corrupt = 1'b0;
    int          wait_cnt = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          done_cnt = 0;
    int          cyc_n = 0;
    int          last_wr_cyc = -1;
    bit          acked_prev = 1'b0;

    always @(negedge clk) begin
        logic [39:0] e;
        cyc_n++;
        if (done_o) done_cnt++;
        if (acked_prev) check("cyc_drop_after_ack", {31'b0, wbm_cyc_o}, 32'd0);
        acked_prev = 1'b0;
        if (wbm_cyc_o && wbm_stb_o) begin
            cur_len++;
            if (!(stall_adr != 8'h00 && wbm_we_o && wbm_adr_o[7:0] == stall_adr) &&
                wait_cnt >= ack_dly) begin
                wbm_ack_i  = 1'b1;
                acked_prev = 1'b1;
                if (wbm_we_o) begin
                    slave_mem[wbm_adr_o[7:0]] = wbm_dat_o;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write actual=%0h:%0h required=none",
                                 wbm_adr_o, wbm_dat_o);
                    end else begin
                        e = exp_q.pop_front();
                        if ({wbm_adr_o[7:0], wbm_dat_o} !== e) begin
                            errors++;
                            $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                                     wbm_adr_o, wbm_dat_o, e[39:32], e[31:0]);
                        end
                    end
                    check("sel", {28'b0, wbm_sel_o}, 32'hF);
                    if (ack_dly == 0 && last_wr_cyc >= 0)
                        check("entry_latency", cyc_n - last_wr_cyc, ENTRY_CYC);
                    last_wr_cyc = cyc_n;
                end else begin
                    wbm_dat_i = (corrupt && wbm_adr_o[7:0] == 8'h20) ? 32'hDEAD
                                                                   : slave_mem[wbm_adr_o[7:0]];
                end
            end else begin
                wbm_ack_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = '0;
            wait_cnt  = 0;
            if (cur_len > 0) last_len = cur_len;
            cur_len = 0;
        end
    end

    // Driver tasks
    task automatic pulse_start(input logic [9:0] a);
        @(negedge clk);
        start_addr_i = a;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", {31'b0, ok}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic prep_run();
        exp_q.delete();
        done_cnt    = 0;
        last_wr_cyc = -1;
        last_len    = 0;
    endtask

    task automatic check_end(input string tag, input int cnt, input logic [1:0] code);
        check({tag, "_cnt"}, {16'b0, entry_cnt_o}, cnt);
        check({tag, "_code"}, {30'b0, err_code_o}, {30'b0, code});
        check({tag, "_err"}, {31'b0, err_o}, {31'b0, (code != 2'd0)});
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [9:0] start_addr;
        int         n_ent;
        bit         use_last;
        int         ack_dly;
        logic [7:0] stall_adr;
        int         exp_cnt;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit seen;
        vecs[0] = '{10'h000, 3, 1'b1, 0, 8'h00, 3, 2'd0};  // basic 3-entry script
        vecs[1] = '{10'h040, 3, 1'b1, 2, 8'h00, 3, 2'd0};  // slow slave
        vecs[2] = '{10'h080, 3, 1'b1, 0, 8'h20, 1, 2'd1};  // entry 2 never acked
        vecs[3] = '{10'h0C0, 6, 1'b0, 0, 8'h00, 4, 2'd2};  // no last bit, overrun at 4
        vecs[4] = '{10'h3FE, 2, 1'b1, 0, 8'h00, 2, 2'd0};  // pointer wraps to 0
        vecs[5] = '{10'h100, 1, 1'b1, 3, 8'h00, 1, 2'd0};  // single entry

        // Reset
        clear_sram();
        for (int i = 0; i < 256; i++) slave_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_code", {30'b0, err_code_o}, 32'd0);
        check("rst_cnt", {16'b0, entry_cnt_o}, 32'd0);
        check("rst_csb", {31'b0, csb_o}, 32'd1);
        check("rst_addr", {22'b0, addr_o}, 32'd0);
        check("rst_cyc", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven scripts
        for (int v = 0; v < 6; v++) begin
            clear_sram();
            load_script(vecs[v].start_addr, vecs[v].n_ent, vecs[v].use_last);
            prep_run();
            for (int i = 0; i < vecs[v].exp_cnt; i++) exp_q.push_back({adr_t[i], dat_t[i]});
            ack_dly   = vecs[v].ack_dly;
            stall_adr = vecs[v].stall_adr;
            pulse_start(vecs[v].start_addr);
            wait_done();
            check_end($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_code);
            if (vecs[v].stall_adr != 8'h00) check("timeout_len", last_len, 255);
            stall_adr = 8'h00;
            ack_dly   = 0;
        end

        // Start while busy is ignored; abort finishes after entry 1
        clear_sram();
        load_script(10'h200, 4, 1'b0);
        sram[10'h300] = 32'h8000_006F;
        sram[10'h301] = 32'h0000_0BAD;
        prep_run();
        exp_q.push_back({8'h10, 32'h1});
        pulse_start(10'h200);
        pulse_start(10'h300);
        abort_i = 1'b1;
        wait_done();
        abort_i = 1'b0;
        check_end("abort", 1, 2'd0);

`ifdef WFG_CFG_LOADER_READBACK_EN
        // Read-back returns a corrupted value for register 0x20
        clear_sram();
        load_script(10'h000, 3, 1'b1);
        prep_run();
        exp_q.push_back({8'h10, 32'h1});
        exp_q.push_back({8'h20, 32'h5});
        corrupt = 1'b1;
        pulse_start(10'h000);
        wait_done();
        corrupt = 1'b0;
        check_end("readback", 1, 2'd3);
`endif

        // Asynchronous reset while a write is outstanding
        clear_sram();
        load_script(10'h000, 3, 1'b1);
        prep_run();
        stall_adr = 8'h10;
        pulse_start(10'h000);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wbm_cyc_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_cyc_seen", {31'b0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("async_stb", {31'b0, wbm_stb_o}, 32'd0);
        check("async_csb", {31'b0, csb_o}, 32'd1);
        check("async_busy", {31'b0, busy_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall_adr = 8'h00;
        repeat (4) @(negedge clk);
        check("async_no_done", done_cnt, 0);
        check("async_idle_state", {28'b0, dbg_state_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
